uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 146 ++++++++++++++
 tb/tb_uart_rx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and frame constants.
package uart_pkg;

  // Data bits per frame (LSB first, no parity).
  localparam int DATA_BITS = 8;
  // Width of the bit-index counter that walks the data bits.
  localparam int BIT_IDX_W = $clog2(DATA_BITS);
  // Width of the per-state clock counter.
  localparam int CNT_W     = 32;

  // Line-level frame states shared by the receiver and the transmitter.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops; both preset so an idle line reads as idle out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data bits LSB first, 1 stop, no parity.
// Start bit is re-checked at its middle; data and stop bits are sampled
// one full bit period apart from there. A low stop bit flags a framing
// error and parks in BREAK until the line returns high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 5208
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 rx_ready,
  output logic                 ferr,
  output logic                 rx_busy
);

  localparam logic [CNT_W-1:0]     HALF_LAST = CNT_W'(CLK_PER_HALF_BIT - 1);
  localparam logic [CNT_W-1:0]     FULL_LAST = CNT_W'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_IDX  = BIT_IDX_W'(DATA_BITS - 1);

  logic w_rxd_s;

  uart_state_e          r_state,    w_state_next;
  logic [CNT_W-1:0]     r_cnt,      w_cnt_next;
  logic [BIT_IDX_W-1:0] r_bit_idx,  w_bit_idx_next;
  logic [DATA_BITS-1:0] r_shift,    w_shift_next;
  logic [DATA_BITS-1:0] r_rdata,    w_rdata_next;
  logic                 r_rx_ready, w_rx_ready_next;
  logic                 r_ferr,     w_ferr_next;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rxd),
    .o_q (w_rxd_s)
  );

  // Next-state logic: the counter restarts at 0 on every state entry and
  // only advances up to its terminal value, so it can never wrap.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_bit_idx_next  = r_bit_idx;
    w_shift_next    = r_shift;
    w_rdata_next    = r_rdata;
    w_rx_ready_next = 1'b0;
    w_ferr_next     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (!w_rxd_s) begin
          w_state_next = ST_START;
        end
      end

      ST_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_next = '0;
          if (!w_rxd_s) begin
            w_state_next   = ST_DATA;
            w_bit_idx_next = '0;
          end else begin
            // Line went back high before mid-start: treat as a glitch.
            w_state_next = ST_IDLE;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      ST_DATA: begin
        if (r_cnt == FULL_LAST) begin
          w_cnt_next     = '0;
          w_shift_next   = {w_rxd_s, r_shift[DATA_BITS-1:1]};
          w_bit_idx_next = r_bit_idx + 1'b1;
          if (r_bit_idx == LAST_IDX) begin
            w_state_next = ST_STOP;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      ST_STOP: begin
        if (r_cnt == FULL_LAST) begin
          w_cnt_next = '0;
          if (w_rxd_s) begin
            w_rdata_next    = r_shift;
            w_rx_ready_next = 1'b1;
            w_state_next    = ST_IDLE;
          end else begin
            w_ferr_next  = 1'b1;
            w_state_next = ST_BREAK;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      ST_BREAK: begin
        // Ignore the low line entirely; only a return to idle re-arms detection.
        w_cnt_next = '0;
        if (w_rxd_s) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_cnt_next   = '0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output pulse registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_rdata    <= '0;
      r_rx_ready <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_bit_idx  <= w_bit_idx_next;
      r_shift    <= w_shift_next;
      r_rdata    <= w_rdata_next;
      r_rx_ready <= w_rx_ready_next;
      r_ferr     <= w_ferr_next;
    end
  end

  assign rdata    = r_rdata;
  assign rx_ready = r_rx_ready;
  assign ferr     = r_ferr;
  assign rx_busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx with a byte scoreboard fed by the line driver.
module tb_uart_rx;

  localparam int HALF     = 8;
  localparam int BIT_CLKS = 2 * HALF;
  localparam int LAT_NOM  = 2 + HALF + 9 * 2 * HALF + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] rdata;
  logic       rx_ready;
  logic       ferr;
  logic       rx_busy;

  int checks    = 0;
  int errors    = 0;
  int ready_cnt = 0;
  int ferr_cnt  = 0;
  int cyc       = 0;
  int fall_cyc  = 0;
  int last_lat  = 0;
  logic prev_ready = 1'b0;
  logic prev_ferr  = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx #(
    .CLK_PER_HALF_BIT (HALF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rdata    (rdata),
    .rx_ready (rx_ready),
    .ferr     (ferr),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every rx_ready pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_ready) begin
        ready_cnt++;
        last_lat = cyc - fall_cyc;
        chk("rx_ready_width", {31'd0, prev_ready}, 32'd0);
        chk("scoreboard_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("rdata", {24'd0, rdata}, {24'd0, e});
          $display("rx byte %02h expected %02h latency %0d", rdata, e, last_lat);
        end
      end
      if (ferr) begin
        ferr_cnt++;
        chk("ferr_width", {31'd0, prev_ferr}, 32'd0);
        $display("ferr pulse, rdata %02h", rdata);
      end
      if (rx_ready || ferr) chk("ready_ferr_exclusive", {31'd0, rx_ready & ferr}, 32'd0);
    end
    prev_ready = rx_ready;
    prev_ferr  = ferr;
  end

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    if (stop_v) exp_q.push_back(b);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_v);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int f0;
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset values
    chk("reset_rdata",    {24'd0, rdata}, 32'h00);
    chk("reset_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("reset_ferr",     {31'd0, ferr}, 32'd0);
    chk("reset_rx_busy",  {31'd0, rx_busy}, 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Single good frame 0x55
    send_frame(8'h55, 1'b1);
    drive_bit(1'b1);
    wait_drain("drain_55");
    chk("count_55", ready_cnt, 32'd1);
    chk("ferr_none_55", ferr_cnt, 32'd0);
    chk("rdata_hold_55", {24'd0, rdata}, 32'h55);
    chk("latency_55", {31'd0, (last_lat >= LAT_NOM - 1) && (last_lat <= LAT_NOM + 1)}, 32'd1);

    // Back-to-back frames, single stop bit
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    drive_bit(1'b1);
    wait_drain("drain_a5_3c");
    chk("count_b2b", ready_cnt, 32'd3);
    chk("rdata_hold_3c", {24'd0, rdata}, 32'h3C);

    // Short low glitch while idle
    rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (3 * BIT_CLKS) @(posedge clk);
    #1;
    chk("glitch_no_ready", ready_cnt, 32'd3);
    chk("glitch_no_ferr", ferr_cnt, 32'd0);
    chk("glitch_rdata", {24'd0, rdata}, 32'h3C);
    chk("glitch_idle", {31'd0, rx_busy}, 32'd0);
    $display("glitch done, rx_busy %0b", rx_busy);

    // Framing error, line held low (break), then recovery
    send_frame(8'hF0, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    chk("break_busy", {31'd0, rx_busy}, 32'd1);
    chk("break_ferr_count", ferr_cnt, 32'd1);
    chk("break_rdata", {24'd0, rdata}, 32'h3C);
    chk("break_no_ready", ready_cnt, 32'd3);
    drive_bit(1'b1);
    send_frame(8'h81, 1'b1);
    drive_bit(1'b1);
    wait_drain("drain_81");
    chk("count_81", ready_cnt, 32'd4);
    chk("rdata_81", {24'd0, rdata}, 32'h81);

    // Reset in the middle of data bit 3 of 0xFF
    r0 = ready_cnt;
    f0 = ferr_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rxd = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
    chk("busy_before_abort", {31'd0, rx_busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_rdata",    {24'd0, rdata}, 32'h00);
    chk("abort_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("abort_ferr",     {31'd0, ferr}, 32'd0);
    chk("abort_rx_busy",  {31'd0, rx_busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12 * BIT_CLKS) @(posedge clk);
    #1;
    chk("abort_no_ready", ready_cnt, r0);
    chk("abort_no_ferr", ferr_cnt, f0);
    chk("abort_idle", {31'd0, rx_busy}, 32'd0);
    send_frame(8'h12, 1'b1);
    drive_bit(1'b1);
    wait_drain("drain_12");
    chk("rdata_12", {24'd0, rdata}, 32'h12);

    // Loopback-style stream from a line-level transmitter model
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h5A, 1'b1);
    drive_bit(1'b1);
    wait_drain("drain_loopback");
    chk("count_total", ready_cnt, r0 + 4);
    chk("rdata_5a", {24'd0, rdata}, 32'h5A);
    chk("ferr_total", ferr_cnt, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
